// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and flag positions for seq_alu
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_RSVD  = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_DBZ  = 2;
  localparam int FLAG_W    = 3;

  // The top two opcode bits set select the iterative unit
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [3:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier and restoring divider
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             op_div_i,
  input  logic             op_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shl, diff;
  logic [2*WIDTH-1:0] prod;

  // Load operand magnitudes on start, then one multiply or divide step per cycle
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    m_d      = m_q;
    a_d      = a_q;
    a_neg    = op_signed_i & a_i[WIDTH-1];
    b_neg    = op_signed_i & b_i[WIDTH-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    sum      = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shl      = {acc_q, lo_q[WIDTH-1]};
    diff     = shl - {1'b0, m_q};
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      div_d    = op_div_i;
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = a_neg;
      dbz_d    = op_div_i && (b_i == '0);
      ovf_d    = op_div_i && op_signed_i && (a_i == MOST_NEG) && (&b_i);
      acc_d    = '0;
      lo_d     = a_mag;
      m_d      = b_mag;
      a_d      = a_i;
    end else if (busy_q) begin
      cnt_d  = cnt_q + CNT_W'(1);
      busy_d = (cnt_q != LAST);
      if (div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shl[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      a_q      <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      a_q      <= a_d;
    end
  end

  // Sign fix-up and divide-by-zero override applied on the way out
  always_comb begin
    prod   = neg_lo_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    done_o = busy_q && (cnt_q == LAST);
    dbz_o  = dbz_q;
    ovf_o  = ovf_q;
    if (dbz_q) begin
      lo_o = '1;
      hi_o = a_q;
    end else if (div_q) begin
      lo_o = neg_lo_q ? -lo_q : lo_q;
      hi_o = neg_hi_q ? -acc_q : acc_q;
    end else begin
      lo_o = prod[WIDTH-1:0];
      hi_o = prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with single-cycle ops and iterative mul/div
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_opcode,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic [WIDTH-1:0] ALU_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               ovf_q, ovf_d;
  logic               sel_md_q, sel_md_d;

  logic               accept, md_start, md_done, md_dbz, md_ovf;
  logic [WIDTH-1:0]   md_lo, md_hi;
  logic [WIDTH-1:0]   alu_res, sum, diff;
  logic               alu_ovf;
  logic [SHAMT_W-1:0] shamt;
  logic [FLAG_W-1:0]  flags;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_muldiv(ALU_opcode);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (md_start),
    .op_div_i    (md_is_div(ALU_opcode)),
    .op_signed_i (md_is_signed(ALU_opcode)),
    .a_i         (Input1),
    .b_i         (Input2),
    .done_o      (md_done),
    .lo_o        (md_lo),
    .hi_o        (md_hi),
    .dbz_o       (md_dbz),
    .ovf_o       (md_ovf)
  );

  // Single-cycle result straight from the request operands
  always_comb begin
    sum     = Input1 + Input2;
    diff    = Input1 - Input2;
    shamt   = Input2[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALU_opcode)
      OP_AND:  alu_res = Input1 & Input2;
      OP_OR:   alu_res = Input1 | Input2;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (Input1[WIDTH-1] == Input2[WIDTH-1]) && (sum[WIDTH-1] != Input1[WIDTH-1]);
      end
      OP_XOR:  alu_res = Input1 ^ Input2;
      OP_NOR:  alu_res = ~(Input1 | Input2);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (Input1 < Input2)};
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (Input1[WIDTH-1] != Input2[WIDTH-1]) && (diff[WIDTH-1] != Input1[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(Input1) < $signed(Input2))};
      OP_SLL:  alu_res = Input1 << shamt;
      OP_SRL:  alu_res = Input1 >> shamt;
      OP_SRA:  alu_res = $signed(Input1) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Control FSM: capture single-cycle results at acceptance, wait on the iterative unit otherwise
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    sel_md_d = sel_md_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sel_md_d = is_muldiv(ALU_opcode);
          if (is_muldiv(ALU_opcode)) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DONE;
            res_d   = alu_res;
            ovf_d   = alu_ovf;
          end
        end
      end
      ST_BUSY: if (md_done) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      sel_md_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      sel_md_q <= sel_md_d;
    end
  end

  // Output mux; zero is only asserted alongside a presented result
  always_comb begin
    ALU_out          = sel_md_q ? md_lo : res_q;
    ALU_hi           = sel_md_q ? md_hi : '0;
    flags            = '0;
    flags[FLAG_ZERO] = out_valid && (ALU_out == '0);
    flags[FLAG_OVF]  = sel_md_q ? md_ovf : ovf_q;
    flags[FLAG_DBZ]  = sel_md_q && md_dbz;
  end

  assign zero = flags[FLAG_ZERO];
  assign ovf  = flags[FLAG_OVF];
  assign dbz  = flags[FLAG_DBZ];

endmodule
